// File: rtl/serial_pkg.sv
// Shared encodings for the serial frame transmitter: FSM states and line levels.
// Optional parity state is present only when SERIAL_TX_PARITY_EN is defined.
package serial_pkg;

  localparam logic IDLE_LEVEL = 1'b0;
  localparam logic START_BIT  = 1'b1;
  localparam logic STOP_BIT   = 1'b1;
  localparam int   GUARD_BITS = 1;

`ifdef SERIAL_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, GUARD} tx_state_e;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, GUARD} tx_state_e;
`endif

endpackage

// File: rtl/serial_tx_scheduler_rr_arbiter.sv
// Round-robin arbiter: first asserted request at or above ptr_i, wrapping around.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IW-1:0]      ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IW-1:0]      idx_o
);

  always_comb begin
    logic found;
    int   j;
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    j       = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = (int'(ptr_i) + k) % NUM_REQ;
      if (!found && req_i[j]) begin
        found      = 1'b1;
        grant_o[j] = 1'b1;
        idx_o      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/serial_tx_scheduler.sv
// Shares one serial line among NUM_REQ requesters, one framed payload at a time.
// Define SERIAL_TX_PARITY_EN to insert an even-parity bit between data and stop.
module serial_tx_scheduler
  import serial_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic                          clk,
  input  logic                          arst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          tx_out,
  output logic                          busy,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          frame_done
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [7:0] CYC_LAST = 8'(CLKS_PER_BIT - 1);

  tx_state_e             state_q, state_d;
  logic [7:0]            cyc_q, cyc_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [IW-1:0]         gid_q, gid_d, ptr_q, ptr_d;
  logic                  tx_q, tx_d;
  logic                  done;
  logic [NUM_REQ-1:0]    grant, ready;
  logic [IW-1:0]         win;
  logic                  bit_end;
`ifdef SERIAL_TX_PARITY_EN
  logic                  par_q, par_d;
`endif

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_arb (
    .req_i  (req_valid),
    .ptr_i  (ptr_q),
    .grant_o(grant),
    .idx_o  (win)
  );

  assign bit_end = (cyc_q == CYC_LAST);

  // tx_d is the level of the next bit, so tx_out changes only at register edges
  always_comb begin
    state_d = state_q;
    cyc_d   = (state_q == IDLE || bit_end) ? 8'd0 : cyc_q + 8'd1;
    bit_d   = bit_q;
    data_d  = data_q;
    gid_d   = gid_q;
    ptr_d   = ptr_q;
    tx_d    = tx_q;
    done    = 1'b0;
    ready   = '0;
`ifdef SERIAL_TX_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        ready = arst ? '0 : grant;
        tx_d  = IDLE_LEVEL;
        if (|req_valid) begin
          state_d = START;
          tx_d    = START_BIT;
          bit_d   = '0;
          data_d  = req_data[int'(win)*DATA_WIDTH +: DATA_WIDTH];
          gid_d   = win;
          ptr_d   = (int'(win) == NUM_REQ - 1) ? '0 : IW'(int'(win) + 1);
`ifdef SERIAL_TX_PARITY_EN
          par_d   = ^req_data[int'(win)*DATA_WIDTH +: DATA_WIDTH];
`endif
        end
      end
      START: if (bit_end) begin
        state_d = DATA;
        tx_d    = data_q[0];
      end
      DATA: if (bit_end) begin
        if (bit_q == BW'(DATA_WIDTH - 1)) begin
          bit_d = '0;
`ifdef SERIAL_TX_PARITY_EN
          state_d = PARITY;
          tx_d    = par_q;
`else
          state_d = STOP;
          tx_d    = STOP_BIT;
`endif
        end else begin
          bit_d  = bit_q + 1'b1;
          data_d = data_q >> 1;
          tx_d   = data_d[0];
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      PARITY: if (bit_end) begin
        state_d = STOP;
        tx_d    = STOP_BIT;
      end
`endif
      STOP: if (bit_end) begin
        state_d = GUARD;
        tx_d    = IDLE_LEVEL;
        bit_d   = '0;
      end
      GUARD: if (bit_end) begin
        if (bit_q == BW'(GUARD_BITS - 1)) begin
          state_d = IDLE;
          bit_d   = '0;
          done    = 1'b1;
        end else begin
          bit_d = bit_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = IDLE_LEVEL;
      end
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      gid_q   <= '0;
      ptr_q   <= '0;
      tx_q    <= IDLE_LEVEL;
`ifdef SERIAL_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      gid_q   <= gid_d;
      ptr_q   <= ptr_d;
      tx_q    <= tx_d;
`ifdef SERIAL_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign req_ready  = ready;
  assign tx_out     = tx_q;
  assign busy       = (state_q != IDLE);
  assign grant_id   = gid_q;
  assign frame_done = done;

endmodule

// File: tb/tb_serial_tx_scheduler.sv
// Directed bench for serial_tx_scheduler: one instance at 1 clk/bit, one at 4 clk/bit.
module tb_serial_tx_scheduler;

  localparam int N  = 4;
  localparam int DW = 8;
`ifdef SERIAL_TX_PARITY_EN
  localparam int          NB     = 12;
  localparam logic [15:0] EXP_A5 = 16'h0D2A;  // 1 10100101 0 1 0
  localparam logic [15:0] EXP_01 = 16'h0C06;  // 1 10000000 1 1 0
`else
  localparam int          NB     = 11;
  localparam logic [15:0] EXP_A5 = 16'h0696;  // 1 10100101 1 0
  localparam logic [15:0] EXP_01 = 16'h0602;  // 1 10000000 1 0
`endif

  logic          clk = 1'b0;
  logic          arst = 1'b1;
  logic [N-1:0]  valid = '0, valid4 = '0;
  logic [N*DW-1:0] data = '0, data4 = '0;
  logic [N-1:0]  ready, ready4;
  logic          tx, tx4, busy, busy4, done, done4;
  logic [1:0]    gid, gid4;

  int errs = 0, checks = 0, cyc = 0;

  serial_tx_scheduler #(.NUM_REQ(N), .DATA_WIDTH(DW), .CLKS_PER_BIT(1)) dut (
    .clk(clk), .arst(arst), .req_valid(valid), .req_data(data), .req_ready(ready),
    .tx_out(tx), .busy(busy), .grant_id(gid), .frame_done(done));

  serial_tx_scheduler #(.NUM_REQ(N), .DATA_WIDTH(DW), .CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .arst(arst), .req_valid(valid4), .req_data(data4), .req_ready(ready4),
    .tx_out(tx4), .busy(busy4), .grant_id(gid4), .frame_done(done4));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(output int idx);
    idx = -1;
    #1;
    for (int n = 0; n < 200; n++) begin
      if (ready != '0) begin
        for (int i = 0; i < N; i++) if (ready[i]) idx = i;
        return;
      end
      tick();
    end
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 200; n++) begin
      if (!busy) return;
      tick();
    end
    chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  initial begin
    int          idx, done_at, acc_prev, held_err;
    logic        busy_all, last;
    logic [15:0] bits;
    int          rr_exp [5] = '{0, 1, 2, 3, 0};

    // reset state, including ready masked while arst is held
    #2;
    chk("rst_tx", 32'(tx), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_gid", 32'(gid), 0);
    valid = 4'b0001;
    #1 chk("rst_ready", 32'(ready), 0);
    valid = '0;
    tick();
    arst = 1'b0;
    tick();

    // single frame, payload A5
    data[7:0] = 8'hA5;
    valid = 4'b0001;
    #1 chk("ready_r0", 32'(ready), 32'h1);
    tick();
    chk("ready_after_acc", 32'(ready), 0);
    chk("gid_r0", 32'(gid), 0);
    valid = '0;
    bits = '0; done_at = -1; busy_all = 1'b1;
    for (int k = 0; k < NB; k++) begin
      bits = {bits[14:0], tx};
      if (done) done_at = k;
      busy_all &= busy;
      tick();
    end
    chk("frame_a5", 32'(bits), 32'(EXP_A5));
    chk("done_at_a5", 32'(done_at), 32'(NB - 1));
    chk("busy_a5", 32'(busy_all), 1);
    chk("post_tx", 32'(tx), 0);
    chk("post_busy", 32'(busy), 0);

    // all four requesting from reset: 0,1,2,3,0 at minimum spacing
    arst = 1'b1; #1 arst = 1'b0;
    data = {8'h44, 8'h33, 8'h22, 8'h11};
    valid = 4'hF;
    acc_prev = 0;
    for (int g = 0; g < 5; g++) begin
      wait_ready(idx);
      chk($sformatf("rr_grant%0d", g), 32'(idx), 32'(rr_exp[g]));
      chk($sformatf("rr_onehot%0d", g), 32'($countones(ready)), 1);
      if (g > 0) chk($sformatf("rr_space%0d", g), 32'(cyc - acc_prev), 32'(NB + 1));
      acc_prev = cyc;
      tick();
      chk($sformatf("rr_ready1cyc%0d", g), 32'(ready), 0);
      chk($sformatf("rr_gid%0d", g), 32'(gid), 32'(rr_exp[g]));
    end
    valid = '0;
    wait_idle();

    // pointer after grant to 2 favours 3 over 1
    arst = 1'b1; #1 arst = 1'b0;
    valid = 4'b0100;
    wait_ready(idx);
    chk("ptr_g2", 32'(idx), 2);
    tick(); valid = '0;
    wait_idle();
    valid = 4'b1010;
    wait_ready(idx);
    chk("ptr_g3", 32'(idx), 3);
    tick(); valid = 4'b0010;
    wait_ready(idx);
    chk("ptr_g1", 32'(idx), 1);
    tick(); valid = '0;
    wait_idle();

    // idle with no requests: line low, gid held, pointer (2) unchanged
    busy_all = 1'b0;
    for (int k = 0; k < 5; k++) begin
      busy_all |= busy | tx;
      tick();
    end
    chk("idle_quiet", 32'(busy_all), 0);
    chk("gid_hold", 32'(gid), 1);
    valid = 4'b1001;
    wait_ready(idx);
    chk("ptr_idle_g3", 32'(idx), 3);
    tick(); valid = '0;
    wait_idle();

    // reset during data bit 3 aborts immediately
    data[23:16] = 8'h08;
    valid = 4'b0100;
    wait_ready(idx);
    chk("abort_g2", 32'(idx), 2);
    tick(); valid = '0;
    for (int k = 0; k < 4; k++) tick();
    chk("abort_d3", 32'(tx), 1);
    arst = 1'b1;
    #1;
    chk("abort_tx", 32'(tx), 0);
    chk("abort_busy", 32'(busy), 0);
    tick();
    arst = 1'b0;
    valid = 4'hF;
    wait_ready(idx);
    chk("abort_next_g0", 32'(idx), 0);
    tick(); valid = '0;
    wait_idle();

    // 4 clocks per bit, payload 01
    data4[7:0] = 8'h01;
    valid4 = 4'b0001;
    #1 chk("ready4", 32'(ready4), 1);
    tick();
    valid4 = '0;
    bits = '0; done_at = -1; busy_all = 1'b1; held_err = 0; last = 1'b0;
    for (int k = 0; k < 4 * NB; k++) begin
      if (k % 4 == 0) bits = {bits[14:0], tx4};
      else if (tx4 !== last) held_err++;
      last = tx4;
      if (done4) done_at = k;
      busy_all &= busy4;
      tick();
    end
    chk("frame4_bits", 32'(bits), 32'(EXP_01));
    chk("frame4_held", 32'(held_err), 0);
    chk("frame4_done_at", 32'(done_at), 32'(4 * NB - 1));
    chk("frame4_busy", 32'(busy_all), 1);
    chk("frame4_end_busy", 32'(busy4), 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
